// File: rtl/alu_74181_pkg.sv
// Shared types and widths for the 74181-style logic datapath
// and its operand sequencer.
package alu_74181_pkg;

    localparam int NIBBLE_W = 4;
    localparam int OPCNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        LOAD_S,
        EXEC,
        RESULT
    } seq_state_t;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Nibble input stream and result output stream of the sequencer.
// master is the surrounding datapath, slave is the sequencer.
interface alu_operand_sequencer_if;
    import alu_74181_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [NIBBLE_W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NIBBLE_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/alu_74181_logic.sv
// Combinational 74181 logic-mode unit (M=1, active-high data).
module alu_74181_logic
    import alu_74181_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic [NIBBLE_W-1:0] s,
    output logic [NIBBLE_W-1:0] f
);

    always_comb begin
        f = '0;
        unique case (s)
            4'h0: f = ~a;
            4'h1: f = ~(a | b);
            4'h2: f = ~a & b;
            4'h3: f = '0;
            4'h4: f = ~(a & b);
            4'h5: f = ~b;
            4'h6: f = a ^ b;
            4'h7: f = a & ~b;
            4'h8: f = ~a | b;
            4'h9: f = ~(a ^ b);
            4'hA: f = b;
            4'hB: f = a & b;
            4'hC: f = '1;
            4'hD: f = a | ~b;
            4'hE: f = a | b;
            4'hF: f = a;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Assembles A/B/S nibble frames, drives the logic unit and holds
// its result on a valid/ready output until consumed.
module alu_operand_sequencer
    import alu_74181_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    alu_operand_sequencer_if.slave bus,
    output logic [NIBBLE_W-1:0] alu_a,
    output logic [NIBBLE_W-1:0] alu_b,
    output logic [NIBBLE_W-1:0] alu_s,
    input  logic [NIBBLE_W-1:0] alu_f,
    output logic                err,
    output logic [OPCNT_W-1:0]  op_count
);

    localparam int TW =
        (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [TW-1:0]       tcnt;
    logic [TW-1:0]       tcnt_nxt;
    logic [NIBBLE_W-1:0] out_q;
    logic                xfer;
    logic                hit;
    logic                load_a;
    logic                load_b;
    logic                load_s;
    logic                cap_f;
    logic                deliver;

    assign bus.in_ready  = (state == LOAD_A) ||
                           (state == LOAD_B) ||
                           (state == LOAD_S);
    assign bus.out_valid = (state == RESULT);
    assign bus.out_data  = out_q;
    assign xfer          = bus.in_valid & bus.in_ready;

    // Counter is zero outside LOAD_B/LOAD_S; a transfer beats the limit.
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = '0;
        hit       = 1'b0;
        load_a    = 1'b0;
        load_b    = 1'b0;
        load_s    = 1'b0;
        cap_f     = 1'b0;
        deliver   = 1'b0;
        if (clear) begin
            state_nxt = LOAD_A;
        end else begin
            unique case (state)
                IDLE: state_nxt = LOAD_A;
                LOAD_A: begin
                    if (xfer) begin
                        load_a    = 1'b1;
                        state_nxt = LOAD_B;
                    end
                end
                LOAD_B, LOAD_S: begin
                    if (xfer) begin
                        load_b    = (state == LOAD_B);
                        load_s    = (state == LOAD_S);
                        state_nxt = (state == LOAD_B) ? LOAD_S : EXEC;
                    end else if (TIMEOUT != 0 && tcnt == TLIM) begin
                        hit       = 1'b1;
                        state_nxt = LOAD_A;
                    end else if (TIMEOUT != 0) begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
                EXEC: begin
                    cap_f     = 1'b1;
                    state_nxt = RESULT;
                end
                RESULT: begin
                    if (bus.out_ready) begin
                        deliver   = 1'b1;
                        state_nxt = LOAD_A;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_s    <= '0;
            out_q    <= '0;
            err      <= 1'b0;
            op_count <= '0;
        end else begin
            err <= hit;
            if (load_a)  alu_a    <= bus.in_data;
            if (load_b)  alu_b    <= bus.in_data;
            if (load_s)  alu_s    <= bus.in_data;
            if (cap_f)   out_q    <= alu_f;
            if (deliver) op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer beside alu_74181_logic,
// built with TIMEOUT=4.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_s;
    logic [3:0] alu_f;
    logic       err;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer_if bus ();

    alu_operand_sequencer #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s),
        .alu_f    (alu_f),
        .err      (err),
        .op_count (op_count)
    );

    alu_74181_logic u_alu (
        .a (alu_a),
        .b (alu_b),
        .s (alu_s),
        .f (alu_f)
    );

    task automatic send(input logic [3:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 20) begin
            $display("FAIL send_wait: in_ready got 0 required 1");
            n_fail++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.out_valid, err} !== 3'b000) begin
            $display("FAIL reset_flags: got %b required 000",
                     {bus.in_ready, bus.out_valid, err});
            n_fail++;
        end
        n_checks++;
        if ({alu_a, alu_b, alu_s, bus.out_data} !== 16'h0) begin
            $display("FAIL reset_regs: got %h required 0000",
                     {alu_a, alu_b, alu_s, bus.out_data});
            n_fail++;
        end
        n_checks++;
        if (op_count !== 8'h00) begin
            $display("FAIL reset_opcnt: got %h required 00", op_count);
            n_fail++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL reset_to_load_a: in_ready got %b required 1",
                     bus.in_ready);
            n_fail++;
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        send(4'hA);
        send(4'h5);
        send(4'h6);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            $display("FAIL basic_exec: valid/ready got %b%b required 00",
                     bus.out_valid, bus.in_ready);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hF) begin
            $display("FAIL basic_result: valid %b data %h required 1 F",
                     bus.out_valid, bus.out_data);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (op_count !== 8'd1 || bus.in_ready !== 1'b1) begin
            $display("FAIL basic_done: opcnt %h ready %b required 01 1",
                     op_count, bus.in_ready);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        send(4'hC);
        send(4'hA);
        send(4'hB);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h8 ||
                bus.in_ready !== 1'b0) begin
                $display("FAIL bp_hold[%0d]: v %b d %h r %b required 1 8 0",
                         i, bus.out_valid, bus.out_data, bus.in_ready);
                n_fail++;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || op_count !== 8'd2) begin
            $display("FAIL bp_release: ready %b opcnt %h required 1 02",
                     bus.in_ready, op_count);
            n_fail++;
        end
    endtask

    task automatic test_timeout();
        int errs = 0;
        send(4'h3);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (err === 1'b1) errs++;
        end
        n_checks++;
        if (errs != 1 || bus.in_ready !== 1'b1) begin
            $display("FAIL timeout_err: pulses %0d ready %b required 1 1",
                     errs, bus.in_ready);
            n_fail++;
        end
        send(4'h1);
        send(4'h2);
        send(4'hE);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h3) begin
            $display("FAIL timeout_next: valid %b data %h required 1 3",
                     bus.out_valid, bus.out_data);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (op_count !== 8'd3) begin
            $display("FAIL timeout_opcnt: got %h required 03", op_count);
            n_fail++;
        end
    endtask

    // B arrives in the very cycle the idle count hits the limit.
    task automatic test_timeout_edge();
        int errs = 0;
        send(4'h5);
        repeat (4) begin
            @(negedge clk);
            if (err === 1'b1) errs++;
        end
        send(4'h6);
        if (err === 1'b1) errs++;
        send(4'h9);
        if (err === 1'b1) errs++;
        @(negedge clk);
        if (err === 1'b1) errs++;
        n_checks++;
        if (errs != 0) begin
            $display("FAIL edge_err: pulses %0d required 0", errs);
            n_fail++;
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hC) begin
            $display("FAIL edge_result: valid %b data %h required 1 C",
                     bus.out_valid, bus.out_data);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (op_count !== 8'd4) begin
            $display("FAIL edge_opcnt: got %h required 04", op_count);
            n_fail++;
        end
    endtask

    task automatic test_clear();
        int seen = 0;
        send(4'h7);
        send(4'h7);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hD;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || err !== 1'b0) begin
            $display("FAIL clear_state: ready %b err %b required 1 0",
                     bus.in_ready, err);
            n_fail++;
        end
        n_checks++;
        if (alu_a !== 4'h7 || alu_s !== 4'h9) begin
            $display("FAIL clear_regs: a %h s %h required 7 9",
                     alu_a, alu_s);
            n_fail++;
        end
        repeat (3) begin
            if (bus.out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen != 0 || op_count !== 8'd4) begin
            $display("FAIL clear_quiet: valids %0d opcnt %h required 0 04",
                     seen, op_count);
            n_fail++;
        end
        send(4'h9);
        send(4'h3);
        send(4'hF);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h9) begin
            $display("FAIL clear_next: valid %b data %h required 1 9",
                     bus.out_valid, bus.out_data);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [7:0] exp = 8'd5;
        logic [7:0] prev;
        logic [3:0] a;
        logic       wrapped = 1'b0;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i);
            prev = op_count;
            send(a);
            send(~a);
            send(4'hF);
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== a) begin
                $display("FAIL wrap_data[%0d]: v %b d %h required 1 %h",
                         i, bus.out_valid, bus.out_data, a);
                n_fail++;
            end
            @(negedge clk);
            exp = exp + 8'd1;
            n_checks++;
            if (op_count !== exp) begin
                $display("FAIL wrap_cnt[%0d]: got %h required %h",
                         i, op_count, exp);
                n_fail++;
            end
            if (prev === 8'hFF && op_count === 8'h00) wrapped = 1'b1;
        end
        n_checks++;
        if (wrapped !== 1'b1) begin
            $display("FAIL wrap_seen: got %b required 1", wrapped);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        send(4'h2);
        send(4'h4);
        send(4'hF);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || op_count === 8'h00) begin
            $display("FAIL ares_pre: valid %b opcnt %h required 1 nonzero",
                     bus.out_valid, op_count);
            n_fail++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b00 ||
            op_count !== 8'h00) begin
            $display("FAIL ares_now: v %b r %b opcnt %h required 0 0 00",
                     bus.out_valid, bus.in_ready, op_count);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            $display("FAIL ares_idle: ready got %b required 0",
                     bus.in_ready);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL ares_load_a: ready got %b required 1",
                     bus.in_ready);
            n_fail++;
        end
        bus.out_ready = 1'b1;
        send(4'h6);
        send(4'hA);
        send(4'h8);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hB) begin
            $display("FAIL ares_frame: valid %b data %h required 1 B",
                     bus.out_valid, bus.out_data);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (op_count !== 8'd1) begin
            $display("FAIL ares_opcnt: got %h required 01", op_count);
            n_fail++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_timeout_edge();
        test_clear();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Upstream sequencing stage for the `alu_74181_logic` unit. It accepts a 4-bit nibble stream over a valid/ready handshake and assembles one frame per operation, in order A, B, S. It drives the registered operands onto the logic unit and captures the unit's combinational result `f`. It then holds that result on a valid/ready output until it is consumed. Both this block and the logic unit sit side by side in the top-level datapath, between the pin-level input interface and the output pins.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum idle cycles allowed mid-frame (in LOAD_B or LOAD_S) before the partial frame is discarded; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `clear`  in  1  synchronous abort; highest priority after reset.
- `in_valid`  in  1  upstream nibble valid.
- `in_ready`  out  1  block can accept a nibble.
- `in_data`  in  4  nibble (A, then B, then S).
- `alu_a`  out  4  registered operand A to the logic unit.
- `alu_b`  out  4  registered operand B to the logic unit.
- `alu_s`  out  4  registered function select to the logic unit.
- `alu_f`  in  4  combinational result from the logic unit.
- `out_valid`  out  1  result held and valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  4  registered result.
- `err`  out  1  one-cycle pulse when a frame is dropped by timeout.
- `op_count`  out  8  number of results delivered; wraps modulo 256.

## Operation
- FSM states are IDLE, LOAD_A, LOAD_B, LOAD_S, EXEC and RESULT.
- Reset:
  - State is IDLE.
  - `alu_a`, `alu_b`, `alu_s`, `out_data`, `op_count` and the timeout counter are all 0.
  - `in_ready`, `out_valid` and `err` are 0.
- IDLE goes to LOAD_A unconditionally on the first clock after reset is released.
- `in_ready` is 1 exactly in LOAD_A, LOAD_B and LOAD_S. A transfer occurs when `in_valid & in_ready`.
- LOAD_A: on a transfer, `alu_a` is loaded with `in_data` and the state goes to LOAD_B.
- LOAD_B: on a transfer, `alu_b` is loaded with `in_data` and the state goes to LOAD_S.
- LOAD_S: on a transfer, `alu_s` is loaded with `in_data` and the state goes to EXEC.
- EXEC lasts one cycle:
  - `out_data` is loaded with `alu_f`.
  - The state goes to RESULT.
- RESULT:
  - `out_valid` is 1 and `out_data` is stable.
  - On `out_ready`, the state goes to LOAD_A and `op_count` increments.
  - `alu_a`, `alu_b` and `alu_s` retain their last values until they are overwritten.
- Timeout:
  - The counter resets to 0 on every transfer and on entry to LOAD_A.
  - It increments each cycle spent in LOAD_B or LOAD_S without a transfer.
  - When it reaches `TIMEOUT`, `err` pulses for one cycle, the state goes to LOAD_A and the counter clears.
  - A transfer in the same cycle the limit is reached wins: the nibble is accepted and there is no `err`.
  - No timeout applies in LOAD_A or RESULT.
- `clear`:
  - From any state other than IDLE, the next state is LOAD_A.
  - `out_valid` drops, the timeout counter clears and `err` is 0.
  - Operand registers and `op_count` are unchanged.
  - A concurrent transfer or `out_ready` is ignored, so `op_count` does not increment.
- Reset asserted mid-frame or mid-result returns everything to reset values immediately, without waiting for a clock edge.

## Timing
- Suppose the S nibble is accepted at edge n.
  - `alu_s` takes its new value after edge n.
  - EXEC occupies cycle n→n+1 and captures `alu_f` at edge n+1.
  - `out_valid` is 1 after edge n+1.
- The earliest result is therefore 2 cycles after the S nibble is accepted.
- A minimal frame takes 3 transfer cycles, 1 EXEC cycle and at least 1 RESULT cycle, so peak throughput is one operation per 5 cycles.
- Input and output phases do not overlap. `in_ready` is 0 throughout EXEC and RESULT, and becomes 1 the cycle after the result is accepted.
- `out_data` must not change while `out_valid` is 1.
- `err` is registered and asserts the cycle after the limit is reached.

## Structure
- Shared package `alu_74181_pkg` holds:
  - the state enum `seq_state_t`;
  - the localparams `NIBBLE_W = 4` and `OPCNT_W = 8`.
- Timeout counter width is `$clog2(TIMEOUT+1)`; for `TIMEOUT == 0`, a 1-bit counter is kept tied at 0.
- No sub-module is used. `alu_74181_logic` is instantiated beside this block in the top level, and the bench instantiates both.

## Test plan
- Send A=0xA, B=0x5, S=0x6 with `out_ready` held at 1. Required: `out_valid` is 1 two cycles after the S transfer, `out_data` is 0xF (XOR), and `op_count` goes to 1.
- Send A=0xC, B=0xA, S=0xB, then hold `out_ready` at 0 for 10 cycles. Required: `out_data` stays 0x8, `in_ready` stays 0, and on release `in_ready` is 1 the next cycle.
- With `TIMEOUT=4`, send A=0x3, then hold `in_valid` at 0. Required: `err` pulses once, the state is LOAD_A, and a following A=0x1, B=0x2, S=0xE frame yields 0x3.
- Send A=0x7, B=0x7 and assert `clear` together with the S transfer. Required: no `out_valid`, `op_count` unchanged, and the next nibble is taken as A.
- Complete 256 frames of S=0xF with A incrementing. Required: every `out_data` equals A, and `op_count` wraps 0xFF→0x00.
- Assert `rst_n` low while in RESULT, asynchronously. Required: `out_valid`, `in_ready` and `op_count` are 0 immediately, and LOAD_A is reached one cycle after release.
